// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : motor_pkg
// Description : Shared definitions for the H-bridge motor sequencer: FSM
//               state encoding, default timing constants and a counter-width
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_DEAD  = 2'd3
  } motor_state_e;

  localparam int c_DEF_PWM_BITS      = 8;
  localparam int c_DEF_PWM_PRESCALE  = 195;
  localparam int c_DEF_RAMP_INTERVAL = 50000;
  localparam int c_DEF_DEADTIME      = 100000;
  localparam int c_DEF_CNT_BITS      = 16;

  // Width of a counter that must hold the value n (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_decoder.sv
`default_nettype none
// ============================================================================
// Module      : quad_decoder
// Description : Quadrature encoder front end. Synchronizes A/B, performs x4
//               decoding and maintains a wrapping two's-complement count.
// Revision    : 1.0 - initial release
// Ports       : clk, reset      clock / synchronous active-high reset
//               i_enc_a/i_enc_b asynchronous encoder channels
//               i_cnt_clr       clear count (wins over a same-cycle tick)
//               o_tick_cnt      signed tick count
//               o_enc_err       1-cycle pulse on a transition changing both bits
// ============================================================================
module quad_decoder #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_enc_a,
  input  logic                i_enc_b,
  input  logic                i_cnt_clr,
  output logic [CNT_BITS-1:0] o_tick_cnt,
  output logic                o_enc_err
);

  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_prev;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_err;
  logic                w_fwd;
  logic                w_rev;
  logic                w_err;

  // Gray sequence {A,B}: 00 -> 01 -> 11 -> 10 -> 00 is the forward direction.
  always_comb begin
    w_fwd = ((r_prev == 2'b00) && (r_sync2 == 2'b01)) ||
            ((r_prev == 2'b01) && (r_sync2 == 2'b11)) ||
            ((r_prev == 2'b11) && (r_sync2 == 2'b10)) ||
            ((r_prev == 2'b10) && (r_sync2 == 2'b00));
    w_rev = ((r_prev == 2'b00) && (r_sync2 == 2'b10)) ||
            ((r_prev == 2'b10) && (r_sync2 == 2'b11)) ||
            ((r_prev == 2'b11) && (r_sync2 == 2'b01)) ||
            ((r_prev == 2'b01) && (r_sync2 == 2'b00));
    w_err = ((r_prev ^ r_sync2) == 2'b11);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b00;
      r_sync2 <= 2'b00;
      r_prev  <= 2'b00;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync1 <= {i_enc_a, i_enc_b};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_err   <= w_err;
      if (i_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_fwd) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_rev) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_tick_cnt = r_cnt;
  assign o_enc_err  = r_err;

endmodule
`default_nettype wire

// File: rtl/hbridge_motor_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hbridge_motor_sequencer
// Description : Per-wheel H-bridge controller. Ramps commanded duty, produces
//               the PWM enable, reverses direction through brake + dead time,
//               and decodes the wheel encoder.
// Revision    : 1.0 - initial release
// Ports       : clk, reset            clock / synchronous active-high reset
//               i_cmd_valid/o_cmd_ready command handshake
//               i_cmd_dir, i_cmd_duty requested direction and duty
//               i_estop               emergency stop (level)
//               i_cnt_clr             clear encoder count
//               i_enc_a, i_enc_b      asynchronous encoder channels
//               o_motor_dir/o_motor_en H-bridge DIR and EN pins
//               o_tick_cnt, o_enc_err encoder count and illegal-step pulse
//               o_state               IDLE=0 RUN=1 BRAKE=2 DEAD=3
// ============================================================================
module hbridge_motor_sequencer
  import motor_pkg::*;
#(
  parameter int PWM_BITS      = c_DEF_PWM_BITS,
  parameter int PWM_PRESCALE  = c_DEF_PWM_PRESCALE,
  parameter int RAMP_INTERVAL = c_DEF_RAMP_INTERVAL,
  parameter int DEADTIME      = c_DEF_DEADTIME,
  parameter int CNT_BITS      = c_DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_dir,
  input  logic [PWM_BITS-1:0] i_cmd_duty,
  input  logic                i_estop,
  input  logic                i_cnt_clr,
  input  logic                i_enc_a,
  input  logic                i_enc_b,
  output logic                o_motor_dir,
  output logic                o_motor_en,
  output logic [CNT_BITS-1:0] o_tick_cnt,
  output logic                o_enc_err,
  output logic [1:0]          o_state
);

  localparam int c_PRE_W  = cnt_width(PWM_PRESCALE);
  localparam int c_RAMP_W = cnt_width(RAMP_INTERVAL);
  localparam int c_DEAD_W = cnt_width(DEADTIME);
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(PWM_PRESCALE - 1);
  localparam logic [c_RAMP_W-1:0] c_RAMP_LAST = c_RAMP_W'(RAMP_INTERVAL - 1);
  localparam logic [c_DEAD_W-1:0] c_DEAD_LOAD = c_DEAD_W'(DEADTIME);
  localparam logic [PWM_BITS-1:0] c_PWM_MAX   = '1;

  motor_state_e        r_state, w_state_nxt;
  logic [PWM_BITS-1:0] r_cur_duty, w_cur_nxt;
  logic [PWM_BITS-1:0] r_target, w_target_nxt;
  logic [PWM_BITS-1:0] r_pend_duty, w_pend_duty_nxt;
  logic                r_pend_dir, w_pend_dir_nxt;
  logic                r_motor_dir, w_motor_dir_nxt;
  logic [c_DEAD_W-1:0] r_dead_cnt, w_dead_nxt;
  logic [c_PRE_W-1:0]  r_pre_cnt;
  logic [c_RAMP_W-1:0] r_ramp_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_shadow;
  logic                r_motor_en;
  logic                w_pwm_tick;
  logic                w_pwm_wrap;
  logic                w_ramp_tick;
  logic                w_ready;
  logic                w_accept;
  logic [PWM_BITS-1:0] w_ramp_goal;

  assign w_pwm_tick  = (r_pre_cnt == c_PRE_LAST);
  assign w_pwm_wrap  = w_pwm_tick && (r_pwm_cnt == c_PWM_MAX);
  assign w_ramp_tick = (r_ramp_cnt == c_RAMP_LAST);
  // Estop blocks acceptance in the same cycle, so a racing command is dropped.
  assign w_ready     = !reset && !i_estop && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_accept    = i_cmd_valid && w_ready;
  assign w_ramp_goal = (r_state == ST_RUN) ? r_target : '0;

  // PWM timebase, period-aligned duty shadow and registered enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_ramp_cnt <= '0;
      r_shadow   <= '0;
      r_motor_en <= 1'b0;
    end else begin
      r_pre_cnt  <= w_pwm_tick ? '0 : r_pre_cnt + 1'b1;
      r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;
      if (w_pwm_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
      if (w_pwm_wrap) begin
        r_shadow <= r_cur_duty;
      end
      r_motor_en <= !i_estop && ((r_state == ST_RUN) || (r_state == ST_BRAKE)) &&
                    (r_pwm_cnt < r_shadow);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_nxt       = r_cur_duty;
    w_target_nxt    = r_target;
    w_pend_duty_nxt = r_pend_duty;
    w_pend_dir_nxt  = r_pend_dir;
    w_motor_dir_nxt = r_motor_dir;
    w_dead_nxt      = r_dead_cnt;

    if (w_ramp_tick) begin
      if (r_cur_duty < w_ramp_goal) begin
        w_cur_nxt = r_cur_duty + 1'b1;
      end else if (r_cur_duty > w_ramp_goal) begin
        w_cur_nxt = r_cur_duty - 1'b1;
      end
    end

    case (r_state)
      ST_IDLE: begin
        if (w_accept && (i_cmd_duty != '0)) begin
          if (i_cmd_dir == r_motor_dir) begin
            w_state_nxt  = ST_RUN;
            w_target_nxt = i_cmd_duty;
          end else begin
            // Motor is already stopped, so go straight to the dead time.
            w_state_nxt     = ST_DEAD;
            w_pend_dir_nxt  = i_cmd_dir;
            w_pend_duty_nxt = i_cmd_duty;
            w_dead_nxt      = c_DEAD_LOAD;
          end
        end
      end
      ST_RUN: begin
        if (w_accept) begin
          if (i_cmd_dir == r_motor_dir) begin
            w_target_nxt = i_cmd_duty;
          end else begin
            w_state_nxt     = ST_BRAKE;
            w_pend_dir_nxt  = i_cmd_dir;
            w_pend_duty_nxt = i_cmd_duty;
          end
        end else if ((r_cur_duty == '0) && (r_target == '0)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BRAKE: begin
        if (r_cur_duty == '0) begin
          w_state_nxt = ST_DEAD;
          w_dead_nxt  = c_DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (r_dead_cnt == '0) begin
          w_motor_dir_nxt = r_pend_dir;
          if (r_pend_duty != '0) begin
            w_state_nxt  = ST_RUN;
            w_target_nxt = r_pend_duty;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_target_nxt = '0;
          end
        end else begin
          w_dead_nxt = r_dead_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Estop pins the FSM in DEAD with a freshly loaded counter every cycle,
    // so the full dead time is counted from release.
    if (i_estop) begin
      w_state_nxt     = ST_DEAD;
      w_cur_nxt       = '0;
      w_target_nxt    = '0;
      w_pend_duty_nxt = '0;
      w_pend_dir_nxt  = r_motor_dir;
      w_motor_dir_nxt = r_motor_dir;
      w_dead_nxt      = c_DEAD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur_duty  <= '0;
      r_target    <= '0;
      r_pend_duty <= '0;
      r_pend_dir  <= 1'b0;
      r_motor_dir <= 1'b0;
      r_dead_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_duty  <= w_cur_nxt;
      r_target    <= w_target_nxt;
      r_pend_duty <= w_pend_duty_nxt;
      r_pend_dir  <= w_pend_dir_nxt;
      r_motor_dir <= w_motor_dir_nxt;
      r_dead_cnt  <= w_dead_nxt;
    end
  end

  quad_decoder #(
    .CNT_BITS (CNT_BITS)
  ) u_quad_decoder (
    .clk        (clk),
    .reset      (reset),
    .i_enc_a    (i_enc_a),
    .i_enc_b    (i_enc_b),
    .i_cnt_clr  (i_cnt_clr),
    .o_tick_cnt (o_tick_cnt),
    .o_enc_err  (o_enc_err)
  );

  assign o_cmd_ready = w_ready;
  assign o_motor_dir = r_motor_dir;
  assign o_motor_en  = r_motor_en;
  assign o_state     = r_state;

endmodule
`default_nettype wire
